legv8_control_fsm: RTL and testbench

Multicycle control unit for the 64-bit LEGv8 datapath. It latches the ROM instruction, decodes it, and drives the 29-bit control word and 64-bit constant into the datapath one state at a time. It reads back the immediate Zero bit and the registered Status flags to resolve branches. It sits between the instruction ROM output and the datapath control inputs and is the only source of `cw` and `k`.

---
 rtl/legv8_control_fsm.sv | 238 +++++++++++++++++++++++
 tb/tb_legv8_control_fsm.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_fsm.sv
// legv8_control_fsm
// Multicycle control unit for the 64-bit LEGv8 datapath. Latches the ROM
// instruction in FETCH, decodes it in EXEC (plus MEM/WB for LDUR) and drives
// the 29-bit control word and 64-bit constant to the datapath. Unknown
// opcodes park the unit in HALT until reset.
module legv8_control_fsm (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] I,
  input  logic [3:0]  Status,
  input  logic        Zero,
  output logic [28:0] cw,
  output logic [63:0] k,
  output logic        halted
);

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd1;
  localparam logic [2:0] ST_MEM   = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [7:0]  OP_BCND = 8'b01010100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  logic [2:0]  r_state;
  logic [31:0] r_ir;
  logic [2:0]  w_nextState;

  logic        w_statusLoad, w_bSel, w_pcSel, w_memWrite, w_regWrite;
  logic [1:0]  w_enable, w_ps;
  logic [4:0]  w_fs, w_sb, w_sa, w_da;
  logic [63:0] w_k;

  logic [10:0] w_op11;
  logic [9:0]  w_op10;
  logic [8:0]  w_op9;
  logic [7:0]  w_op8;
  logic [5:0]  w_op6;
  logic        w_isRType;
  logic        w_condTrue;
  logic        w_flagV, w_flagC, w_flagZ, w_flagN;
  logic [63:0] w_imm9Sext, w_imm19Sext, w_imm26Sext, w_imm12, w_shamt, w_movz;

  assign w_op11 = r_ir[31:21];
  assign w_op10 = r_ir[31:22];
  assign w_op9  = r_ir[31:23];
  assign w_op8  = r_ir[31:24];
  assign w_op6  = r_ir[31:26];

  assign w_isRType = (w_op11 == OP_ADD) || (w_op11 == OP_SUB) || (w_op11 == OP_ADDS) ||
                     (w_op11 == OP_SUBS) || (w_op11 == OP_AND) || (w_op11 == OP_ORR) ||
                     (w_op11 == OP_EOR);

  assign w_imm9Sext  = {{55{r_ir[20]}}, r_ir[20:12]};
  assign w_imm19Sext = {{45{r_ir[23]}}, r_ir[23:5]};
  assign w_imm26Sext = {{38{r_ir[25]}}, r_ir[25:0]};
  assign w_imm12     = {52'd0, r_ir[21:10]};
  assign w_shamt     = {58'd0, r_ir[15:10]};
  assign w_movz      = {48'd0, r_ir[20:5]} << {r_ir[22:21], 4'b0000};

  assign {w_flagV, w_flagC, w_flagZ, w_flagN} = Status;

  // State and instruction register; I is captured only while in FETCH
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_FETCH) r_ir <= I;
    end
  end

  // B.cond evaluation against the registered flags; 1111 is never taken
  always_comb begin
    w_condTrue = 1'b0;
    case (r_ir[3:0])
      4'b0000: w_condTrue = w_flagZ;
      4'b0001: w_condTrue = !w_flagZ;
      4'b0010: w_condTrue = w_flagC;
      4'b0011: w_condTrue = !w_flagC;
      4'b0100: w_condTrue = w_flagN;
      4'b0101: w_condTrue = !w_flagN;
      4'b0110: w_condTrue = w_flagV;
      4'b0111: w_condTrue = !w_flagV;
      4'b1000: w_condTrue = w_flagC && !w_flagZ;
      4'b1001: w_condTrue = !w_flagC || w_flagZ;
      4'b1010: w_condTrue = (w_flagN == w_flagV);
      4'b1011: w_condTrue = (w_flagN != w_flagV);
      4'b1100: w_condTrue = !w_flagZ && (w_flagN == w_flagV);
      4'b1101: w_condTrue = w_flagZ || (w_flagN != w_flagV);
      4'b1110: w_condTrue = 1'b1;
      default: w_condTrue = 1'b0;
    endcase
  end

  // Control word, constant and next state; everything defaults to zero so
  // unmatched opcodes naturally emit a null control word on their way to HALT
  always_comb begin
    w_statusLoad = 1'b0;
    w_bSel       = 1'b0;
    w_pcSel      = 1'b0;
    w_memWrite   = 1'b0;
    w_regWrite   = 1'b0;
    w_enable     = 2'b00;
    w_ps         = 2'b00;
    w_fs         = 5'd0;
    w_sb         = 5'd0;
    w_sa         = 5'd0;
    w_da         = 5'd0;
    w_k          = 64'd0;
    w_nextState  = ST_FETCH;
    case (r_state)
      ST_FETCH: w_nextState = ST_EXEC;
      ST_EXEC: begin
        w_nextState = ST_FETCH;
        if (w_isRType) begin
          w_sa         = r_ir[9:5];
          w_sb         = r_ir[20:16];
          w_da         = r_ir[4:0];
          w_bSel       = 1'b1;
          w_regWrite   = 1'b1;
          w_ps         = 2'b01;
          w_statusLoad = (w_op11 == OP_ADDS) || (w_op11 == OP_SUBS);
          if ((w_op11 == OP_ADD) || (w_op11 == OP_ADDS))      w_fs = FS_ADD;
          else if ((w_op11 == OP_SUB) || (w_op11 == OP_SUBS)) w_fs = FS_SUB;
          else if (w_op11 == OP_AND)                          w_fs = FS_AND;
          else if (w_op11 == OP_ORR)                          w_fs = FS_ORR;
          else                                                w_fs = FS_EOR;
        end else if ((w_op11 == OP_LSL) || (w_op11 == OP_LSR)) begin
          w_sa       = r_ir[9:5];
          w_da       = r_ir[4:0];
          w_regWrite = 1'b1;
          w_ps       = 2'b01;
          w_fs       = (w_op11 == OP_LSL) ? FS_LSL : FS_LSR;
          w_k        = w_shamt;
        end else if (w_op11 == OP_STUR) begin
          w_sa       = r_ir[9:5];
          w_sb       = r_ir[4:0];
          w_fs       = FS_ADD;
          w_k        = w_imm9Sext;
          w_enable   = 2'b11;
          w_memWrite = 1'b1;
          w_ps       = 2'b01;
        end else if (w_op11 == OP_LDUR) begin
          w_nextState = ST_MEM;
        end else if (w_op11 == OP_BR) begin
          w_sa    = r_ir[9:5];
          w_pcSel = 1'b1;
          w_ps    = 2'b10;
        end else if ((w_op10 == OP_ADDI) || (w_op10 == OP_SUBI)) begin
          w_sa       = r_ir[9:5];
          w_da       = r_ir[4:0];
          w_regWrite = 1'b1;
          w_ps       = 2'b01;
          w_fs       = (w_op10 == OP_ADDI) ? FS_ADD : FS_SUB;
          w_k        = w_imm12;
        end else if (w_op9 == OP_MOVZ) begin
          w_sa       = 5'd31;
          w_da       = r_ir[4:0];
          w_regWrite = 1'b1;
          w_ps       = 2'b01;
          w_fs       = FS_ORR;
          w_k        = w_movz;
        end else if ((w_op8 == OP_CBZ) || (w_op8 == OP_CBNZ)) begin
          w_sa   = r_ir[4:0];
          w_sb   = 5'd31;
          w_bSel = 1'b1;
          w_fs   = FS_ADD;
          w_k    = w_imm19Sext;
          w_ps   = ((w_op8 == OP_CBZ) ? Zero : !Zero) ? 2'b11 : 2'b01;
        end else if ((w_op8 == OP_BCND) && (r_ir[3:0] != 4'b1111)) begin
          w_k  = w_imm19Sext;
          w_ps = w_condTrue ? 2'b11 : 2'b01;
        end else if ((w_op6 == OP_B) || (w_op6 == OP_BL)) begin
          w_ps = 2'b11;
          w_k  = w_imm26Sext;
          if (w_op6 == OP_BL) begin
            w_da       = 5'd30;
            w_enable   = 2'b10;
            w_regWrite = 1'b1;
          end
        end else begin
          w_nextState = ST_HALT;
        end
      end
      ST_MEM, ST_WB: begin
        w_sa     = r_ir[9:5];
        w_fs     = FS_ADD;
        w_k      = w_imm9Sext;
        w_enable = 2'b01;
        if (r_state == ST_WB) begin
          w_da        = r_ir[4:0];
          w_regWrite  = 1'b1;
          w_ps        = 2'b01;
          w_nextState = ST_FETCH;
        end else begin
          w_nextState = ST_WB;
        end
      end
      ST_HALT: w_nextState = ST_HALT;
      default: w_nextState = ST_FETCH;
    endcase
  end

  assign cw = {w_statusLoad, w_bSel, w_pcSel, w_memWrite, w_regWrite,
               w_enable, w_ps, w_fs, w_sb, w_sa, w_da};
  assign k      = w_k;
  assign halted = (r_state == ST_HALT);

endmodule

// File: tb/tb_legv8_control_fsm.sv
// tb_legv8_control_fsm
// Table of single-instruction vectors plus hand-written LDUR, reset and HALT
// sequences. Expected outputs are queued when stimulus is driven and popped
// when the DUT presents the corresponding cycle.
module tb_legv8_control_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] I;
  logic [3:0]  Status;
  logic        Zero;
  logic [28:0] cw;
  logic [63:0] k;
  logic        halted;

  localparam logic [4:0] FADD = 5'b01000;
  localparam logic [4:0] FSUB = 5'b01001;
  localparam logic [4:0] FAND = 5'b00000;
  localparam logic [4:0] FORR = 5'b00100;
  localparam logic [4:0] FEOR = 5'b01100;
  localparam logic [4:0] FLSL = 5'b10000;
  localparam logic [4:0] FLSR = 5'b10100;

  typedef struct packed {
    logic [28:0] cw;
    logic [63:0] k;
    logic        halted;
  } expect_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  status;
    logic        zero;
    logic [28:0] cw;
    logic [63:0] k;
  } vec_t;

  expect_t expQ[$];
  vec_t    vecs[$];
  int      nChecks = 0;
  int      nFail   = 0;

  legv8_control_fsm dut (
    .clock  (clock),
    .reset  (reset),
    .I      (I),
    .Status (Status),
    .Zero   (Zero),
    .cw     (cw),
    .k      (k),
    .halted (halted)
  );

  always #5 clock = ~clock;

  // Hard bound on simulation time in case the sequencing ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [28:0] mkCw(input logic sl, input logic bs, input logic pc,
                                       input logic mw, input logic rw, input logic [1:0] en,
                                       input logic [1:0] ps, input logic [4:0] fs,
                                       input logic [4:0] sb, input logic [4:0] sa,
                                       input logic [4:0] da);
    return {sl, bs, pc, mw, rw, en, ps, fs, sb, sa, da};
  endfunction

  function automatic logic [31:0] rIns(input logic [10:0] opc, input logic [4:0] rm,
                                       input logic [5:0] sh, input logic [4:0] rn,
                                       input logic [4:0] rd);
    return {opc, rm, sh, rn, rd};
  endfunction

  function automatic logic [31:0] iIns(input logic [9:0] opc, input logic [11:0] imm,
                                       input logic [4:0] rn, input logic [4:0] rd);
    return {opc, imm, rn, rd};
  endfunction

  function automatic logic [31:0] dIns(input logic [10:0] opc, input logic [8:0] imm9,
                                       input logic [4:0] rn, input logic [4:0] rt);
    return {opc, imm9, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] cbIns(input logic [7:0] opc, input logic [18:0] imm,
                                        input logic [4:0] rt);
    return {opc, imm, rt};
  endfunction

  function automatic logic [31:0] bcIns(input logic [18:0] imm, input logic [3:0] cond);
    return {8'b01010100, imm, 1'b0, cond};
  endfunction

  task automatic addVec(input string n, input logic [31:0] ins, input logic [3:0] st,
                        input logic z, input logic [28:0] c, input logic [63:0] kk);
    vec_t v;
    v.name = n; v.instr = ins; v.status = st; v.zero = z; v.cw = c; v.k = kk;
    vecs.push_back(v);
  endtask

  task automatic pushExpect(input logic [28:0] c, input logic [63:0] kk, input logic h);
    expect_t e;
    e.cw = c; e.k = kk; e.halted = h;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] st, input logic z);
    I      = instr;
    Status = st;
    Zero   = z;
  endtask

  task automatic checkOutput(input string tag);
    expect_t e;
    nChecks++;
    if (expQ.size() == 0) begin
      nFail++;
      $display("[TB] FAIL %s: no expectation queued, got cw=%h k=%h halted=%b", tag, cw, k, halted);
    end else begin
      e = expQ.pop_front();
      if ({cw, k, halted} !== e) begin
        nFail++;
        $display("[TB] FAIL %s: got cw=%h k=%h halted=%b, expected cw=%h k=%h halted=%b",
                 tag, cw, k, halted, e.cw, e.k, e.halted);
      end
    end
  endtask

  task automatic stepCycle;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Two-cycle instruction starting from a FETCH negedge; I is trashed during
  // EXEC to confirm the DUT decodes from its latched copy.
  task automatic runSimple(input string tag, input logic [31:0] instr, input logic [3:0] st,
                           input logic z, input logic [28:0] expCw, input logic [63:0] expK);
    applyStimulus(instr, st, z);
    pushExpect(29'd0, 64'd0, 1'b0);
    pushExpect(expCw, expK, 1'b0);
    checkOutput({tag, "/fetch"});
    stepCycle();
    I = 32'hFFFF_FFFF;
    checkOutput({tag, "/exec"});
    stepCycle();
  endtask

  logic [31:0] addIns, ldurIns;
  logic [28:0] addCw, memCw, wbCw;

  initial begin
    addIns  = rIns(11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3);
    addCw   = mkCw(0, 1, 0, 0, 1, 2'b00, 2'b01, FADD, 5'd2, 5'd1, 5'd3);
    ldurIns = dIns(11'b11111000010, 9'h1F8, 5'd2, 5'd3);
    memCw   = mkCw(0, 0, 0, 0, 0, 2'b01, 2'b00, FADD, 5'd0, 5'd2, 5'd0);
    wbCw    = mkCw(0, 0, 0, 0, 1, 2'b01, 2'b01, FADD, 5'd0, 5'd2, 5'd3);

    addVec("add",   addIns, 4'h0, 0, addCw, 64'd0);
    addVec("sub",   rIns(11'b11001011000, 5'd29, 6'd0, 5'd30, 5'd31), 4'h0, 0,
           mkCw(0, 1, 0, 0, 1, 2'b00, 2'b01, FSUB, 5'd29, 5'd30, 5'd31), 64'd0);
    addVec("adds",  rIns(11'b10101011000, 5'd6, 6'd0, 5'd5, 5'd4), 4'h0, 0,
           mkCw(1, 1, 0, 0, 1, 2'b00, 2'b01, FADD, 5'd6, 5'd5, 5'd4), 64'd0);
    addVec("subs",  rIns(11'b11101011000, 5'd6, 6'd0, 5'd5, 5'd4), 4'h0, 0,
           mkCw(1, 1, 0, 0, 1, 2'b00, 2'b01, FSUB, 5'd6, 5'd5, 5'd4), 64'd0);
    addVec("and",   rIns(11'b10001010000, 5'd9, 6'd0, 5'd8, 5'd7), 4'h0, 0,
           mkCw(0, 1, 0, 0, 1, 2'b00, 2'b01, FAND, 5'd9, 5'd8, 5'd7), 64'd0);
    addVec("orr",   rIns(11'b10101010000, 5'd9, 6'd0, 5'd8, 5'd7), 4'h0, 0,
           mkCw(0, 1, 0, 0, 1, 2'b00, 2'b01, FORR, 5'd9, 5'd8, 5'd7), 64'd0);
    addVec("eor",   rIns(11'b11001010000, 5'd9, 6'd0, 5'd8, 5'd7), 4'h0, 0,
           mkCw(0, 1, 0, 0, 1, 2'b00, 2'b01, FEOR, 5'd9, 5'd8, 5'd7), 64'd0);
    addVec("lsl",   rIns(11'b11010011011, 5'd7, 6'd4, 5'd2, 5'd1), 4'h0, 0,
           mkCw(0, 0, 0, 0, 1, 2'b00, 2'b01, FLSL, 5'd0, 5'd2, 5'd1), 64'd4);
    addVec("lsr",   rIns(11'b11010011010, 5'd0, 6'd63, 5'd2, 5'd1), 4'h0, 0,
           mkCw(0, 0, 0, 0, 1, 2'b00, 2'b01, FLSR, 5'd0, 5'd2, 5'd1), 64'd63);
    addVec("addi",  iIns(10'b1001000100, 12'hFFF, 5'd2, 5'd1), 4'h0, 0,
           mkCw(0, 0, 0, 0, 1, 2'b00, 2'b01, FADD, 5'd0, 5'd2, 5'd1), 64'd4095);
    addVec("subi",  iIns(10'b1101000100, 12'h001, 5'd3, 5'd2), 4'h0, 0,
           mkCw(0, 0, 0, 0, 1, 2'b00, 2'b01, FSUB, 5'd0, 5'd3, 5'd2), 64'd1);
    addVec("movz48", {9'b110100101, 2'b11, 16'hABCD, 5'd5}, 4'h0, 0,
           mkCw(0, 0, 0, 0, 1, 2'b00, 2'b01, FORR, 5'd0, 5'd31, 5'd5), 64'hABCD_0000_0000_0000);
    addVec("movz0", {9'b110100101, 2'b00, 16'h1234, 5'd6}, 4'h0, 0,
           mkCw(0, 0, 0, 0, 1, 2'b00, 2'b01, FORR, 5'd0, 5'd31, 5'd6), 64'h1234);
    addVec("sturneg", dIns(11'b11111000000, 9'h1F8, 5'd2, 5'd3), 4'h0, 0,
           mkCw(0, 0, 0, 1, 0, 2'b11, 2'b01, FADD, 5'd3, 5'd2, 5'd0), 64'hFFFF_FFFF_FFFF_FFF8);
    addVec("sturpos", dIns(11'b11111000000, 9'd255, 5'd4, 5'd5), 4'h0, 0,
           mkCw(0, 0, 0, 1, 0, 2'b11, 2'b01, FADD, 5'd5, 5'd4, 5'd0), 64'd255);
    addVec("b",     {6'b000101, 26'h3FF_FFFC}, 4'h0, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 64'hFFFF_FFFF_FFFF_FFFC);
    addVec("bl",    {6'b100101, 26'd100}, 4'h0, 0,
           mkCw(0, 0, 0, 0, 1, 2'b10, 2'b11, 5'd0, 5'd0, 5'd0, 5'd30), 64'd100);
    addVec("br",    rIns(11'b11010110000, 5'd31, 6'd0, 5'd30, 5'd0), 4'h0, 0,
           mkCw(0, 0, 1, 0, 0, 2'b00, 2'b10, 5'd0, 5'd0, 5'd30, 5'd0), 64'd0);
    addVec("cbz_z1", cbIns(8'b10110100, 19'd3, 5'd2), 4'h0, 1,
           mkCw(0, 1, 0, 0, 0, 2'b00, 2'b11, FADD, 5'd31, 5'd2, 5'd0), 64'd3);
    addVec("cbz_z0", cbIns(8'b10110100, 19'd3, 5'd2), 4'h0, 0,
           mkCw(0, 1, 0, 0, 0, 2'b00, 2'b01, FADD, 5'd31, 5'd2, 5'd0), 64'd3);
    addVec("cbnz_z1", cbIns(8'b10110101, 19'h7FFFF, 5'd2), 4'h0, 1,
           mkCw(0, 1, 0, 0, 0, 2'b00, 2'b01, FADD, 5'd31, 5'd2, 5'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    addVec("cbnz_z0", cbIns(8'b10110101, 19'd3, 5'd2), 4'h0, 0,
           mkCw(0, 1, 0, 0, 0, 2'b00, 2'b11, FADD, 5'd31, 5'd2, 5'd0), 64'd3);
    addVec("b.lt_n", bcIns(19'd16, 4'b1011), 4'b0001, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 64'd16);
    addVec("b.ge_n", bcIns(19'd16, 4'b1010), 4'b0001, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0), 64'd16);
    addVec("b.eq_z", bcIns(19'h7FFFE, 4'b0000), 4'b0010, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 64'hFFFF_FFFF_FFFF_FFFE);
    addVec("b.ne_z", bcIns(19'd8, 4'b0001), 4'b0010, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0), 64'd8);
    addVec("b.hs_c", bcIns(19'd8, 4'b0010), 4'b0100, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 64'd8);
    addVec("b.lo_c", bcIns(19'd8, 4'b0011), 4'b0100, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0), 64'd8);
    addVec("b.vs_v", bcIns(19'd8, 4'b0110), 4'b1000, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 64'd8);
    addVec("b.gt_0", bcIns(19'd8, 4'b1100), 4'b0000, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 64'd8);
    addVec("b.le_vn", bcIns(19'd8, 4'b1101), 4'b1001, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0), 64'd8);
    addVec("b.al",  bcIns(19'd8, 4'b1110), 4'b0000, 0,
           mkCw(0, 0, 0, 0, 0, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0), 64'd8);

    // Reset held for two cycles, then ADDI X1,XZR,#5
    reset = 1'b1;
    applyStimulus(32'h910017E1, 4'h0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    pushExpect(29'd0, 64'd0, 1'b0);
    checkOutput("reset/held");
    reset = 1'b0;
    runSimple("addi_after_reset", 32'h910017E1, 4'h0, 1'b0, 29'h11403E1, 64'd5);

    for (int i = 0; i < vecs.size(); i++)
      runSimple(vecs[i].name, vecs[i].instr, vecs[i].status, vecs[i].zero, vecs[i].cw, vecs[i].k);

    // LDUR X3,[X2,#-8]: FETCH, EXEC, MEM, WB, then straight back to FETCH
    applyStimulus(ldurIns, 4'h0, 1'b0);
    pushExpect(29'd0, 64'd0, 1'b0);
    pushExpect(29'd0, 64'd0, 1'b0);
    pushExpect(memCw, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    pushExpect(wbCw,  64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    checkOutput("ldur/fetch");
    stepCycle();
    checkOutput("ldur/exec");
    stepCycle();
    checkOutput("ldur/mem");
    stepCycle();
    checkOutput("ldur/wb");
    stepCycle();
    runSimple("add_after_ldur", addIns, 4'h0, 1'b0, addCw, 64'd0);

    // Reset during the MEM cycle of LDUR must suppress WB
    applyStimulus(ldurIns, 4'h0, 1'b0);
    pushExpect(29'd0, 64'd0, 1'b0);
    pushExpect(29'd0, 64'd0, 1'b0);
    pushExpect(memCw, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    pushExpect(29'd0, 64'd0, 1'b0);
    checkOutput("midreset/fetch");
    stepCycle();
    checkOutput("midreset/exec");
    stepCycle();
    checkOutput("midreset/mem");
    reset = 1'b1;
    stepCycle();
    checkOutput("midreset/after");
    reset = 1'b0;
    runSimple("add_after_midreset", addIns, 4'h0, 1'b0, addCw, 64'd0);

    // Unmatched opcode parks the unit in HALT until reset
    applyStimulus(32'h0000_0000, 4'h0, 1'b0);
    pushExpect(29'd0, 64'd0, 1'b0);
    pushExpect(29'd0, 64'd0, 1'b0);
    checkOutput("halt/fetch");
    stepCycle();
    checkOutput("halt/exec");
    stepCycle();
    I = addIns;
    for (int c = 0; c < 12; c++) begin
      pushExpect(29'd0, 64'd0, 1'b1);
      checkOutput("halt/hold");
      stepCycle();
    end
    reset = 1'b1;
    stepCycle();
    pushExpect(29'd0, 64'd0, 1'b0);
    checkOutput("halt/reset");
    reset = 1'b0;
    runSimple("add_after_halt", addIns, 4'h0, 1'b0, addCw, 64'd0);

    // B.cond with cond=1111 is treated as illegal
    applyStimulus(bcIns(19'd8, 4'b1111), 4'hF, 1'b0);
    pushExpect(29'd0, 64'd0, 1'b0);
    pushExpect(29'd0, 64'd0, 1'b0);
    checkOutput("bnv/fetch");
    stepCycle();
    checkOutput("bnv/exec");
    stepCycle();
    for (int c = 0; c < 2; c++) begin
      pushExpect(29'd0, 64'd0, 1'b1);
      checkOutput("bnv/halt");
      stepCycle();
    end
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    runSimple("add_after_bnv", addIns, 4'h0, 1'b0, addCw, 64'd0);

    nChecks++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
